// File: rtl/util_pkg.sv
`default_nettype none
// ============================================================================
// Module      : util_pkg
// Description : Shared types and constants for the display brightness block.
//               Holds the ramp FSM state encoding, the default microsecond
//               prescale and a helper that picks the ramp direction.
// Revision    : 1.0 - initial release
// ============================================================================
package util_pkg;

    localparam int DISP_US_PER_MS = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } bright_state_t;

    // Direction the output has to move to reach the target.
    function automatic bright_state_t bright_dir(input logic [7:0] cur,
                                                 input logic [7:0] tgt);
        bright_state_t dir;
        dir = IDLE;
        if (tgt > cur) begin
            dir = UP;
        end else if (tgt < cur) begin
            dir = DOWN;
        end
        return dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_tick.sv
`default_nettype none
// ============================================================================
// Module      : disp_tick
// Description : Ramp timebase. Divides the 1 us pulse down to a 1 ms tick and
//               then counts ms ticks 0..ramp_rate, firing step_tick on the
//               last count.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               tsc_1ppus  - one-cycle pulse per microsecond
//               ramp_rate  - ms per brightness step minus one
//               step_tick  - one-cycle pulse when a brightness step is due
// Revision    : 1.0 - initial release
// ============================================================================
module disp_tick
    import util_pkg::*;
#(
    parameter int US_PER_MS = DISP_US_PER_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tsc_1ppus,
    input  logic [7:0] ramp_rate,
    output logic       step_tick
);

    localparam int                c_US_W   = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
    localparam logic [c_US_W-1:0] c_US_MAX = c_US_W'(US_PER_MS - 1);
    localparam logic [c_US_W-1:0] c_US_ONE = c_US_W'(1);

    logic [c_US_W-1:0] us_cnt_q;
    logic [c_US_W-1:0] us_cnt_d;
    logic [7:0]        step_cnt_q;
    logic [7:0]        step_cnt_d;
    logic              ms_tick;

    // Microsecond prescaler: ms_tick fires on the pulse that wraps the count.
    always_comb begin
        us_cnt_d = us_cnt_q;
        ms_tick  = 1'b0;
        if (tsc_1ppus) begin
            if (us_cnt_q == c_US_MAX) begin
                us_cnt_d = '0;
                ms_tick  = 1'b1;
            end else begin
                us_cnt_d = us_cnt_q + c_US_ONE;
            end
        end
    end

    // Step counter compares against the live ramp_rate, so a rate change
    // takes effect in the same cycle. A count stranded above a lowered rate
    // is pulled back to zero without producing a step.
    always_comb begin
        step_cnt_d = step_cnt_q;
        step_tick  = 1'b0;
        if (step_cnt_q > ramp_rate) begin
            step_cnt_d = '0;
        end else if (ms_tick) begin
            if (step_cnt_q == ramp_rate) begin
                step_cnt_d = '0;
                step_tick  = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            us_cnt_q   <= '0;
            step_cnt_q <= '0;
        end else begin
            us_cnt_q   <= us_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/disp_bright.sv
`default_nettype none
// ============================================================================
// Module      : disp_bright
// Description : Display brightness ramp controller. Selects a day/night/off
//               target and walks disp_pdm toward it one LSB per step_tick,
//               or jumps straight to it when ramp_rate is zero.
// Ports       : clk, rst      - clock and synchronous active-high reset
//               tsc_1ppus     - one-cycle pulse per microsecond
//               disp_en       - 1 = lit, 0 = fade to dark
//               night         - selects night brightness
//               bright_day    - day brightness target
//               bright_night  - night brightness target
//               ramp_rate     - ms per step minus one, 0 = bypass
//               disp_pdm      - brightness to the PDM dimmer
//               ramp_busy     - high while disp_pdm is away from target
// Revision    : 1.0 - initial release
// ============================================================================
module disp_bright
    import util_pkg::*;
#(
    parameter int US_PER_MS = DISP_US_PER_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tsc_1ppus,
    input  logic       disp_en,
    input  logic       night,
    input  logic [7:0] bright_day,
    input  logic [7:0] bright_night,
    input  logic [7:0] ramp_rate,
    output logic [7:0] disp_pdm,
    output logic       ramp_busy
);

    logic [7:0]    target;
    logic          step_tick;
    bright_state_t state_q;
    bright_state_t state_d;
    logic [7:0]    disp_pdm_q;
    logic [7:0]    disp_pdm_d;

    disp_tick #(
        .US_PER_MS (US_PER_MS)
    ) u_disp_tick (
        .clk       (clk),
        .rst       (rst),
        .tsc_1ppus (tsc_1ppus),
        .ramp_rate (ramp_rate),
        .step_tick (step_tick)
    );

    always_comb begin
        target = 8'd0;
        if (disp_en) begin
            target = night ? bright_night : bright_day;
        end
    end

    // The step direction comes from the live comparison rather than the
    // registered state, so a target crossing mid-ramp reverses on the very
    // next step with no stray step in the old direction. Stepping only while
    // strictly below/above target keeps the value inside 0..255.
    always_comb begin
        state_d    = bright_dir(disp_pdm_q, target);
        disp_pdm_d = disp_pdm_q;
        if (ramp_rate == 8'd0) begin
            disp_pdm_d = target;
        end else if (step_tick) begin
            case (state_d)
                UP:      disp_pdm_d = disp_pdm_q + 8'd1;
                DOWN:    disp_pdm_d = disp_pdm_q - 8'd1;
                default: disp_pdm_d = disp_pdm_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            disp_pdm_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            disp_pdm_q <= disp_pdm_d;
        end
    end

    // The registered state is the busy flag: it rises the cycle after a
    // mismatch is seen and drops the cycle after disp_pdm lands on target.
    assign disp_pdm  = disp_pdm_q;
    assign ramp_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_disp_bright.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_disp_bright
// Description : Self-checking bench for disp_bright with a 10 us millisecond
//               and one tsc_1ppus pulse every second clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_bright;

    localparam int US_PER_MS = 10;

    typedef struct {
        logic       en;
        logic       nt;
        logic [7:0] day;
        logic [7:0] ngt;
        logic [7:0] exp_pdm;
    } vec_t;

    logic       clk          = 1'b0;
    logic       rst          = 1'b1;
    logic       tsc_1ppus    = 1'b0;
    logic       disp_en      = 1'b0;
    logic       night        = 1'b0;
    logic [7:0] bright_day   = 8'd0;
    logic [7:0] bright_night = 8'd0;
    logic [7:0] ramp_rate    = 8'd0;
    logic [7:0] disp_pdm;
    logic       ramp_busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses   = 0;
    vec_t vecs [8];

    disp_bright #(
        .US_PER_MS (US_PER_MS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tsc_1ppus    (tsc_1ppus),
        .disp_en      (disp_en),
        .night        (night),
        .bright_day   (bright_day),
        .bright_night (bright_night),
        .ramp_rate    (ramp_rate),
        .disp_pdm     (disp_pdm),
        .ramp_busy    (ramp_busy)
    );

    always #5 clk = ~clk;

    // One clock: count the us pulse consumed at this edge, then toggle it so
    // a pulse is presented on every second edge.
    task automatic tick();
        @(posedge clk);
        if (tsc_1ppus && !rst) pulses++;
        #1;
        tsc_1ppus = ~tsc_1ppus;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance until disp_pdm changes; n returns the number of clocks taken.
    task automatic wait_change(input string name, input int max_cyc, output int n);
        logic [7:0] prev;
        prev = disp_pdm;
        n    = 0;
        while (disp_pdm == prev && n < max_cyc) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, (disp_pdm != prev) ? 1 : 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{1'b1, 1'b0, 8'd200, 8'd50,  8'd200};
        vecs[1] = '{1'b1, 1'b1, 8'd200, 8'd50,  8'd50};
        vecs[2] = '{1'b0, 1'b1, 8'd200, 8'd50,  8'd0};
        vecs[3] = '{1'b1, 1'b1, 8'd0,   8'd255, 8'd255};
        vecs[4] = '{1'b1, 1'b0, 8'd17,  8'd255, 8'd17};
        vecs[5] = '{1'b0, 1'b0, 8'd17,  8'd255, 8'd0};
        vecs[6] = '{1'b1, 1'b0, 8'd255, 8'd0,   8'd255};
        vecs[7] = '{1'b1, 1'b1, 8'd255, 8'd0,   8'd0};

        // Reset dominates even with an enabled bypass target.
        rst        = 1'b1;
        disp_en    = 1'b1;
        bright_day = 8'd100;
        ramp_rate  = 8'd0;
        ticks(3);
        check("reset_pdm",  disp_pdm,  0);
        check("reset_busy", ramp_busy, 0);

        // Fade-in 0 -> 4 at ramp_rate 1: 20 us = 40 clocks per step.
        disp_en    = 1'b0;
        bright_day = 8'd4;
        ramp_rate  = 8'd1;
        tick();
        rst = 1'b0;
        ticks(5);
        check("fade_idle_pdm", disp_pdm, 0);
        disp_en = 1'b1;
        wait_change("fade_1", 100, n);
        check("fade_1_val", disp_pdm, 1);
        for (int v = 2; v <= 4; v++) begin
            wait_change("fade_step", 100, n);
            check("fade_step_val", disp_pdm, v);
            check("fade_step_clocks", n, 40);
        end
        check("fade_busy_at_4", ramp_busy, 1);
        tick();
        check("fade_busy_after_4", ramp_busy, 0);
        check("fade_hold_4", disp_pdm, 4);

        // Bypass table: target appears one clock later, busy at most one clock.
        ramp_rate = 8'd0;
        for (int i = 0; i < 8; i++) begin
            disp_en      = vecs[i].en;
            night        = vecs[i].nt;
            bright_day   = vecs[i].day;
            bright_night = vecs[i].ngt;
            tick();
            check("bypass_pdm", disp_pdm, vecs[i].exp_pdm);
            tick();
            check("bypass_busy_low", ramp_busy, 0);
        end

        // Day -> night at ramp_rate 2: 10,9,8,7 at 30 us = 60 clocks.
        disp_en    = 1'b1;
        night      = 1'b0;
        bright_day = 8'd10;
        tick();
        check("dn_start", disp_pdm, 10);
        ramp_rate    = 8'd2;
        bright_night = 8'd7;
        tick();
        night = 1'b1;
        wait_change("dn_9", 100, n);
        check("dn_9_val", disp_pdm, 9);
        wait_change("dn_8", 100, n);
        check("dn_8_val", disp_pdm, 8);
        check("dn_8_clocks", n, 60);
        wait_change("dn_7", 100, n);
        check("dn_7_val", disp_pdm, 7);
        check("dn_7_clocks", n, 60);
        ticks(130);
        check("dn_hold", disp_pdm, 7);
        check("dn_busy", ramp_busy, 0);

        // Reversal: ramping up at 5 toward 9, target drops to 3.
        night     = 1'b0;
        ramp_rate = 8'd0;
        rst       = 1'b1;
        tick();
        rst        = 1'b0;
        bright_day = 8'd5;
        tick();
        check("rev_start", disp_pdm, 5);
        ramp_rate  = 8'd1;
        bright_day = 8'd9;
        ticks(10);
        check("rev_pre_pdm",  disp_pdm,  5);
        check("rev_pre_busy", ramp_busy, 1);
        bright_day = 8'd3;
        wait_change("rev_4", 100, n);
        check("rev_4_val", disp_pdm, 4);
        wait_change("rev_3", 100, n);
        check("rev_3_val", disp_pdm, 3);
        check("rev_3_clocks", n, 40);
        ticks(50);
        check("rev_hold", disp_pdm, 3);

        // Saturation at the top.
        ramp_rate  = 8'd0;
        bright_day = 8'd254;
        tick();
        check("sat_hi_start", disp_pdm, 254);
        ramp_rate  = 8'd1;
        bright_day = 8'd255;
        wait_change("sat_hi", 100, n);
        check("sat_hi_val", disp_pdm, 255);
        ticks(100);
        check("sat_hi_hold", disp_pdm, 255);
        check("sat_hi_busy", ramp_busy, 0);

        // Saturation at the bottom: fade off from 1 and stay at 0.
        ramp_rate  = 8'd0;
        bright_day = 8'd1;
        tick();
        check("sat_lo_start", disp_pdm, 1);
        ramp_rate = 8'd1;
        disp_en   = 1'b0;
        wait_change("sat_lo", 100, n);
        check("sat_lo_val", disp_pdm, 0);
        ticks(100);
        check("sat_lo_hold", disp_pdm, 0);
        check("sat_lo_busy", ramp_busy, 0);

        // Reset mid-ramp, then restart the ramp from 0.
        disp_en    = 1'b1;
        ramp_rate  = 8'd0;
        bright_day = 8'd50;
        tick();
        check("rst_mid_start", disp_pdm, 50);
        ramp_rate  = 8'd1;
        bright_day = 8'd100;
        ticks(2);
        check("rst_mid_busy_pre", ramp_busy, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_pdm",  disp_pdm,  0);
        check("rst_mid_busy", ramp_busy, 0);
        tick();
        rst    = 1'b0;
        pulses = 0;
        wait_change("rst_first_step", 100, n);
        check("rst_first_val",    disp_pdm, 1);
        check("rst_first_pulses", pulses,   2 * US_PER_MS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
